// File: rtl/apb_master_driver_fsm_if.sv
// Command/response port and APB requester bus bundled for the APB master driver engine.
// The master modport is the engine's view; the slave modport is the agent/slave-side view.
interface apb_master_driver_fsm_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NO_OF_SLAVES = 1,
  parameter int SEL_WIDTH    = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Command port
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [STRB_WIDTH-1:0]   req_strb;
  logic [2:0]              req_prot;
  logic [SEL_WIDTH-1:0]    req_slave_idx;

  // Response strobe
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_slverr;
  logic                    rsp_timeout;
  logic [7:0]              rsp_wait_cycles;

  // APB bus
  logic [NO_OF_SLAVES-1:0] psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [STRB_WIDTH-1:0]   pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, req_slave_idx,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_wait_cycles,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, req_slave_idx,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_wait_cycles,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_master_driver_fsm.sv
// APB3/APB4 requester engine: accepts one command, runs SETUP/ACCESS with a wait-state
// timeout, and returns a one-cycle response strobe with read data and error status.
module apb_master_driver_fsm #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,  // 8, 16 or 32
  parameter int NO_OF_SLAVES = 1,
  parameter int SEL_WIDTH    = 1,   // >= clog2(NO_OF_SLAVES), minimum 1
  parameter int TIMEOUT      = 16   // 1..255 ACCESS cycles with pready low
) (
  input logic                    pclk,
  input logic                    preset_n,
  apb_master_driver_fsm_if.master bus
);

  localparam int          STRB_WIDTH   = DATA_WIDTH / 8;
  localparam logic [31:0] SLAVE_COUNT  = 32'(NO_OF_SLAVES);
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0]  TIMEOUT_VAL  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR
  } state_t;

  state_t state_q, state_d;

  // Registered bus and response outputs
  logic [NO_OF_SLAVES-1:0] psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q,   pstrb_d;
  logic [2:0]              pprot_q,   pprot_d;
  logic [7:0]              wait_cnt_q, wait_cnt_d;

  logic                    rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                    rsp_slverr_q,  rsp_slverr_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [7:0]              rsp_wait_q,    rsp_wait_d;

  logic                    in_access;
  logic                    done_ok;
  logic                    timeout_hit;
  logic                    finish;
  logic                    req_ready;
  logic                    accept;
  logic                    idx_ok;
  logic                    load;
  logic [NO_OF_SLAVES-1:0] psel_onehot;

  // Completion and abort are decided in the last ACCESS cycle, so the response lands one cycle later.
  assign in_access   = (state_q == ST_ACCESS);
  assign done_ok     = in_access && bus.pready;
  assign timeout_hit = in_access && !bus.pready && (wait_cnt_q == TIMEOUT_LAST);
  assign finish      = done_ok || timeout_hit;

  assign req_ready = preset_n && ((state_q == ST_IDLE) || finish);
  assign accept    = bus.req_valid && req_ready;
  assign idx_ok    = (32'(bus.req_slave_idx) < SLAVE_COUNT);
  assign load      = accept && idx_ok;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first; a missing branch would otherwise infer a latch.
    psel_onehot = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      psel_onehot[i] = (bus.req_slave_idx == SEL_WIDTH'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = idx_ok ? ST_SETUP : ST_ERR;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (finish) begin
          if (accept) state_d = idx_ok ? ST_SETUP : ST_ERR;
          else        state_d = ST_IDLE;
        end
      end
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    psel_d     = psel_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    pprot_d    = pprot_q;
    penable_d  = (state_d == ST_ACCESS);
    wait_cnt_d = wait_cnt_q;

    if (load) begin
      psel_d   = psel_onehot;
      pwrite_d = bus.req_write;
      paddr_d  = bus.req_addr;
      pprot_d  = bus.req_prot;
      pwdata_d = bus.req_write ? bus.req_wdata : '0;
      pstrb_d  = bus.req_write ? bus.req_strb  : '0;
    end else if (accept || finish) begin
      // Bus goes quiet; address and data are left as they were, strobes are not.
      psel_d  = '0;
      pstrb_d = '0;
    end

    if (state_d == ST_SETUP) begin
      wait_cnt_d = 8'd0;
    end else if (in_access && !bus.pready && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_slverr_d  = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_wait_d    = 8'd0;

    if (done_ok) begin
      rsp_valid_d  = 1'b1;
      rsp_slverr_d = bus.pslverr;
      rsp_wait_d   = wait_cnt_q;
      if (!pwrite_q && !bus.pslverr) rsp_rdata_d = bus.prdata;
    end else if (timeout_hit) begin
      rsp_valid_d   = 1'b1;
      rsp_slverr_d  = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_wait_d    = TIMEOUT_VAL;
    end else if (state_q == ST_ERR) begin
      rsp_valid_d  = 1'b1;
      rsp_slverr_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= ST_IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      wait_cnt_q    <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_wait_q    <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_wait_q    <= rsp_wait_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.psel            = psel_q;
  assign bus.penable         = penable_q;
  assign bus.pwrite          = pwrite_q;
  assign bus.paddr           = paddr_q;
  assign bus.pwdata          = pwdata_q;
  assign bus.pstrb           = pstrb_q;
  assign bus.pprot           = pprot_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_slverr      = rsp_slverr_q;
  assign bus.rsp_timeout     = rsp_timeout_q;
  assign bus.rsp_wait_cycles = rsp_wait_q;

endmodule

// File: tb/tb_apb_master_driver_fsm.sv
// Directed bench for apb_master_driver_fsm: write, waited read, timeout, back-to-back,
// decode error, slave error and mid-transfer reset, with hand-computed expectations.
module tb_apb_master_driver_fsm;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int NO_OF_SLAVES = 2;
  localparam int SEL_WIDTH    = 2;
  localparam int TIMEOUT      = 16;

  logic pclk;
  logic preset_n;
  int   checks;
  int   errors;

  apb_master_driver_fsm_if #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .NO_OF_SLAVES(NO_OF_SLAVES),
    .SEL_WIDTH   (SEL_WIDTH)
  ) bus ();

  apb_master_driver_fsm #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .NO_OF_SLAVES(NO_OF_SLAVES),
    .SEL_WIDTH   (SEL_WIDTH),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .bus     (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge before sampling or driving.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [1:0] idx);
    bus.req_valid     = 1'b1;
    bus.req_write     = wr;
    bus.req_addr      = addr;
    bus.req_wdata     = wdata;
    bus.req_strb      = strb;
    bus.req_prot      = 3'b010;
    bus.req_slave_idx = idx;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    preset_n          = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.req_strb      = '0;
    bus.req_prot      = '0;
    bus.req_slave_idx = '0;
    bus.pready        = 1'b0;
    bus.prdata        = '0;
    bus.pslverr       = 1'b0;

    // Reset state
    #3;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_psel",      bus.psel, 0);
    check("rst_penable",   bus.penable, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    step();
    step();
    preset_n = 1'b1;
    #1;
    check("idle_req_ready", bus.req_ready, 1);
    check("idle_paddr",     bus.paddr, 0);

    // Write, zero wait states
    request(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0);
    bus.pready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    #1;
    check("wr_setup_psel",    bus.psel, 2'b01);
    check("wr_setup_penable", bus.penable, 0);
    check("wr_setup_paddr",   bus.paddr, 32'h10);
    check("wr_setup_pwdata",  bus.pwdata, 32'hDEAD_BEEF);
    check("wr_setup_pstrb",   bus.pstrb, 4'hF);
    check("wr_setup_pwrite",  bus.pwrite, 1);
    check("wr_setup_pprot",   bus.pprot, 3'b010);
    check("wr_setup_ready",   bus.req_ready, 0);
    step();
    check("wr_access_penable", bus.penable, 1);
    check("wr_access_psel",    bus.psel, 2'b01);
    check("wr_access_paddr",   bus.paddr, 32'h10);
    check("wr_access_pwdata",  bus.pwdata, 32'hDEAD_BEEF);
    check("wr_access_rsp",     bus.rsp_valid, 0);
    step();
    check("wr_rsp_valid",   bus.rsp_valid, 1);
    check("wr_rsp_slverr",  bus.rsp_slverr, 0);
    check("wr_rsp_wait",    bus.rsp_wait_cycles, 0);
    check("wr_rsp_rdata",   bus.rsp_rdata, 0);
    check("wr_idle_psel",   bus.psel, 0);
    check("wr_idle_penable",bus.penable, 0);
    check("wr_idle_pstrb",  bus.pstrb, 0);
    check("wr_idle_paddr",  bus.paddr, 32'h10);
    step();
    check("wr_rsp_drop", bus.rsp_valid, 0);

    // Read with three wait states
    request(1'b0, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, 2'd1);
    bus.pready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    check("rd_setup_psel",   bus.psel, 2'b10);
    check("rd_setup_pwdata", bus.pwdata, 0);
    check("rd_setup_pstrb",  bus.pstrb, 0);
    check("rd_setup_paddr",  bus.paddr, 32'h24);
    step();
    for (int i = 0; i < 4; i++) begin
      check("rd_access_penable", bus.penable, 1);
      check("rd_access_pwdata",  bus.pwdata, 0);
      check("rd_access_pstrb",   bus.pstrb, 0);
      check("rd_access_rsp",     bus.rsp_valid, 0);
      if (i == 3) begin
        bus.pready = 1'b1;
        bus.prdata = 32'h1234_5678;
      end
      step();
    end
    bus.pready = 1'b0;
    bus.prdata = '0;
    check("rd_rsp_valid",  bus.rsp_valid, 1);
    check("rd_rsp_rdata",  bus.rsp_rdata, 32'h1234_5678);
    check("rd_rsp_wait",   bus.rsp_wait_cycles, 3);
    check("rd_rsp_slverr", bus.rsp_slverr, 0);
    check("rd_idle_penable", bus.penable, 0);

    // Timeout abort
    request(1'b0, 32'h0000_0030, 32'h0, 4'h0, 2'd0);
    bus.prdata = 32'hAAAA_AAAA;
    step();
    bus.req_valid = 1'b0;
    step();
    for (int i = 1; i <= 16; i++) begin
      check("to_access_penable", bus.penable, 1);
      check("to_access_psel",    bus.psel, 2'b01);
      #1;
      check("to_req_ready", bus.req_ready, (i == 16) ? 64'd1 : 64'd0);
      step();
    end
    check("to_psel",        bus.psel, 0);
    check("to_penable",     bus.penable, 0);
    check("to_rsp_valid",   bus.rsp_valid, 1);
    check("to_rsp_timeout", bus.rsp_timeout, 1);
    check("to_rsp_slverr",  bus.rsp_slverr, 1);
    check("to_rsp_rdata",   bus.rsp_rdata, 0);
    check("to_rsp_wait",    bus.rsp_wait_cycles, 16);
    bus.prdata = '0;
    step();

    // Back-to-back writes with req_valid held high
    request(1'b1, 32'h0000_0100, 32'h1111_1111, 4'h3, 2'd0);
    bus.pready = 1'b1;
    step();
    request(1'b1, 32'h0000_0104, 32'h2222_2222, 4'hC, 2'd0);
    check("b2b_setup1_paddr",  bus.paddr, 32'h100);
    check("b2b_setup1_pwdata", bus.pwdata, 32'h1111_1111);
    step();
    #1;
    check("b2b_access1_penable", bus.penable, 1);
    check("b2b_access1_psel",    bus.psel, 2'b01);
    check("b2b_access1_paddr",   bus.paddr, 32'h100);
    check("b2b_access1_ready",   bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("b2b_setup2_penable", bus.penable, 0);
    check("b2b_setup2_psel",    bus.psel, 2'b01);
    check("b2b_setup2_paddr",   bus.paddr, 32'h104);
    check("b2b_setup2_pwdata",  bus.pwdata, 32'h2222_2222);
    check("b2b_setup2_pstrb",   bus.pstrb, 4'hC);
    check("b2b_rsp1_valid",     bus.rsp_valid, 1);
    step();
    check("b2b_access2_penable", bus.penable, 1);
    check("b2b_access2_rsp",     bus.rsp_valid, 0);
    step();
    check("b2b_rsp2_valid", bus.rsp_valid, 1);
    check("b2b_idle_psel",  bus.psel, 0);

    // Decode error: slave index beyond NO_OF_SLAVES
    request(1'b0, 32'h0000_0050, 32'h0, 4'h0, 2'd3);
    step();
    bus.req_valid = 1'b0;
    #1;
    check("dec_err_psel",    bus.psel, 0);
    check("dec_err_penable", bus.penable, 0);
    check("dec_err_ready",   bus.req_ready, 0);
    check("dec_err_rsp",     bus.rsp_valid, 0);
    step();
    check("dec_rsp_valid",   bus.rsp_valid, 1);
    check("dec_rsp_slverr",  bus.rsp_slverr, 1);
    check("dec_rsp_rdata",   bus.rsp_rdata, 0);
    check("dec_rsp_wait",    bus.rsp_wait_cycles, 0);
    check("dec_rsp_timeout", bus.rsp_timeout, 0);
    check("dec_idle_psel",   bus.psel, 0);

    // Slave error on a read
    request(1'b0, 32'h0000_0060, 32'h0, 4'h0, 2'd1);
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hCAFE_F00D;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    check("slv_rsp_valid",  bus.rsp_valid, 1);
    check("slv_rsp_slverr", bus.rsp_slverr, 1);
    check("slv_rsp_rdata",  bus.rsp_rdata, 0);
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    bus.pready  = 1'b0;
    step();

    // Asynchronous reset in ACCESS after two wait cycles
    request(1'b0, 32'h0000_0070, 32'h0, 4'h0, 2'd0);
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    step();
    check("rst_mid_penable", bus.penable, 1);
    #2;
    preset_n = 1'b0;
    #1;
    check("rst_mid_psel",    bus.psel, 0);
    check("rst_mid_penable0",bus.penable, 0);
    check("rst_mid_paddr",   bus.paddr, 0);
    check("rst_mid_ready",   bus.req_ready, 0);
    check("rst_mid_rsp",     bus.rsp_valid, 0);
    step();
    check("rst_hold_rsp", bus.rsp_valid, 0);
    preset_n = 1'b1;
    step();
    check("rst_after_rsp", bus.rsp_valid, 0);
    request(1'b0, 32'h0000_0080, 32'h0, 4'h0, 2'd1);
    bus.pready = 1'b1;
    bus.prdata = 32'h0BAD_CAFE;
    step();
    bus.req_valid = 1'b0;
    check("post_rst_psel", bus.psel, 2'b10);
    step();
    step();
    check("post_rst_rsp_valid", bus.rsp_valid, 1);
    check("post_rst_rsp_rdata", bus.rsp_rdata, 32'h0BAD_CAFE);
    check("post_rst_rsp_wait",  bus.rsp_wait_cycles, 0);
    check("post_rst_slverr",    bus.rsp_slverr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_driver_fsm.md
Name: apb_master_driver_fsm

Overview:
- Synthesizable APB3/APB4 requester (initiator) engine. It drives the bus that the slave-side monitor observes.
- Accepts one transfer request on a valid/ready command port and sequences the APB SETUP and ACCESS phases.
- Holds ACCESS through slave wait states, with a wait-state timeout.
- Returns read data and error status on a one-cycle response strobe. Sits between master agent stimulus and the apb_if signals.

Parameters:
- ADDR_WIDTH, 32, width of paddr / req_addr
- DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32
- NO_OF_SLAVES, 1, width of psel one-hot vector
- SEL_WIDTH, 1, width of req_slave_idx, at least clog2(NO_OF_SLAVES), minimum 1
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; must be 1..255

Ports:
- pclk  in  1  APB clock
- preset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  transfer address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte strobes
- req_prot  in  3  protection attributes
- req_slave_idx  in  SEL_WIDTH  target slave index
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_slverr  out  1  pslverr captured, or decode/timeout error
- rsp_timeout  out  1  transfer aborted by timeout
- rsp_wait_cycles  out  8  ACCESS cycles with pready low
- psel  out  NO_OF_SLAVES  one-hot slave select
- penable  out  1  ACCESS phase
- pwrite  out  1  direction
- paddr  out  ADDR_WIDTH  address
- pwdata  out  DATA_WIDTH  write data
- pstrb  out  DATA_WIDTH/8  byte strobes
- pprot  out  3  protection
- pready  in  1  slave ready
- prdata  in  DATA_WIDTH  read data
- pslverr  in  1  slave error

Behaviour:
- Clock and reset: one clock, pclk. Reset preset_n is asynchronous, active-low. While preset_n is low, every output is 0, the state is IDLE and the counters are 0. Outputs clear immediately, including mid-transfer. No response is generated for a transfer killed by reset.
- States: IDLE, SETUP, ACCESS, ERR.
- req_ready is combinational: 1 in IDLE, or in ACCESS when pready=1 or the timeout is reached. It is 0 in SETUP and ERR.
- Request accepted with a valid req_slave_idx < NO_OF_SLAVES: go to SETUP next cycle.
  - psel[idx]=1, penable=0.
  - paddr, pwrite and pprot are registered from the request.
  - pwdata and pstrb are registered for writes and forced to 0 for reads.
- Request accepted with req_slave_idx >= NO_OF_SLAVES: go to ERR for one cycle. No psel is asserted. On leaving ERR: rsp_valid=1, rsp_slverr=1, rsp_rdata=0, rsp_wait_cycles=0. Then go to IDLE.
- SETUP: always goes to ACCESS after exactly one cycle, with penable=1.
- Hold rule: paddr, pwrite, pwdata, pstrb, pprot and psel stay stable from SETUP until the cycle after ACCESS completes.
- ACCESS with pready=0: stay in ACCESS and increment the wait counter (saturating at 255).
- ACCESS with pready=1: transfer completes.
  - Next cycle: rsp_valid=1, rsp_rdata=prdata if read and no error (else 0), rsp_slverr=pslverr, rsp_wait_cycles=counter.
  - prdata and pslverr are sampled only on the completion edge.
- Timeout: when the wait count reaches TIMEOUT while pready stays 0, abort.
  - Next cycle: psel=0, penable=0.
  - rsp_valid=1, rsp_timeout=1, rsp_slverr=1, rsp_rdata=0, rsp_wait_cycles=TIMEOUT.
- After completion or abort:
  - If req_valid was 1 in the completing cycle, go directly to SETUP for the new request. penable drops to 0 and psel is reloaded; there is no IDLE cycle.
  - Otherwise go to IDLE with psel=0 and penable=0. Address, data and strobe outputs keep their last value; pstrb is cleared.
- Latency:
  - Minimum from acceptance to rsp_valid is 3 cycles (SETUP, ACCESS, response) with zero wait states.
  - Response fields are valid only while rsp_valid=1. rsp_valid is never asserted in consecutive cycles unless back-to-back zero-wait transfers make that possible.
  - There is no response backpressure.
- The wait counter clears on entry to SETUP.

Test Plan:
- Write, idx=0, addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, pready=1 in first ACCESS -> SETUP then ACCESS visible on bus with addr/data stable; rsp_valid 3 cycles after acceptance; slverr=0, wait=0.
- Read addr 0x24 with pready low for 3 cycles, prdata 0x1234_5678 -> penable high for 4 cycles; pwdata=0 and pstrb=0 throughout; rsp_rdata=0x1234_5678, rsp_wait_cycles=3.
- Read with pready held 0, TIMEOUT=16 -> abort after 16 wait cycles; psel and penable drop; rsp_timeout=1, slverr=1, rdata=0, wait=16.
- Two writes back-to-back with req_valid held high, zero wait -> second SETUP immediately follows first ACCESS (penable 1->0, psel continuous); no IDLE cycle; two rsp_valid pulses.
- NO_OF_SLAVES=2, req_slave_idx=3 -> no psel activity; rsp_valid 2 cycles after acceptance with slverr=1; pslverr=1 on a valid transfer yields slverr=1 and rdata=0.
- preset_n pulled low during ACCESS with 2 wait cycles elapsed -> all outputs 0 asynchronously; no rsp_valid; after release, a new read completes normally with wait=0.
